rpxx_mbxfer: RTL and testbench

//  Drive-side Massbus data-transfer sequencer; sits downstream of the massbus slave modport inside a disk drive.

---
 rtl/rpxx_pkg.sv | 33 +++
 rtl/rpxx_mbxfer.sv | 186 ++++++++++++++++++
 tb/tb_rpxx_mbxfer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/rpxx_pkg.sv
// ============================================================================
// Module  : rpxx_pkg
// Brief   : Massbus transfer function codes and sequencer state/command types.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rpxx_pkg;

    localparam logic [4:0] FUN_READ  = 5'o34;
    localparam logic [4:0] FUN_WRITE = 5'o30;
    localparam logic [4:0] FUN_WRCHK = 5'o24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_REQ   = 3'd2,
        ST_PUT   = 3'd3,
        ST_INC   = 3'd4,
        ST_WAIT  = 3'd5,
        ST_PAD   = 3'd6,
        ST_DONE  = 3'd7
    } xfer_state_t;

    typedef enum logic [1:0] {
        CMD_READ  = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_WRCHK = 2'd2
    } cmd_t;

endpackage

`default_nettype wire

// File: rtl/rpxx_mbxfer.sv
// ============================================================================
// Module  : rpxx_mbxfer
// Brief   : Drive-side Massbus data-transfer sequencer (read/write/write-check).
//           Optional macro RPXX_MBXFER_PAR_EN enables parity-invert on READ words.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rpxx_mbxfer #(
    parameter int SECWORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mbINIT,
    input  logic        mbGO,
    input  logic [4:0]  mbFUN,
    input  logic        mbPAT,
    input  logic        mbWCZ,
    input  logic        mbACKI,
    input  logic [35:0] mbDATAI,
    output logic        mbREQO,
    output logic [35:0] mbDATAO,
    output logic        mbINCWC,
    output logic        mbINCBA,
    output logic        mbWCE,
    output logic        mbNPRO,
    output logic        mbINVPAR,
    input  logic [35:0] bufRDAT,
    input  logic        bufRVLD,
    output logic        bufRRDY,
    output logic [35:0] bufWDAT,
    output logic        bufWVLD,
    input  logic        bufWRDY,
    output logic        secDONE,
    output logic        xferDONE
);
    import rpxx_pkg::*;

    localparam int             CW       = $clog2(SECWORDS);
    localparam logic [CW-1:0]  CNT_LAST = CW'(SECWORDS - 1);

    xfer_state_t   state_q, state_d, next_word;
    cmd_t          cmd_q, cmd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [35:0]   data_q, data_d;
    logic          wce_q, wce_d;
    logic          secdone_q, secdone_d;

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        wce_d     = wce_q;
        secdone_d = 1'b0;
        next_word = (cmd_q == CMD_WRITE) ? ST_REQ : ST_FETCH;

        unique case (state_q)
            ST_IDLE: begin
                if (mbGO) begin
                    case (mbFUN)
                        FUN_READ: begin
                            cmd_d = CMD_READ;  state_d = ST_FETCH; cnt_d = '0; wce_d = 1'b0;
                        end
                        FUN_WRCHK: begin
                            cmd_d = CMD_WRCHK; state_d = ST_FETCH; cnt_d = '0; wce_d = 1'b0;
                        end
                        FUN_WRITE: begin
                            cmd_d = CMD_WRITE; state_d = ST_REQ;   cnt_d = '0; wce_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_FETCH: begin
                if (bufRVLD) begin
                    data_d  = bufRDAT;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mbACKI) begin
                    if (cmd_q == CMD_WRITE) begin
                        data_d  = mbDATAI;
                        state_d = ST_PUT;
                    end else begin
                        if (cmd_q == CMD_WRCHK && mbDATAI != data_q) wce_d = 1'b1;
                        state_d = ST_INC;
                    end
                end
            end
            ST_PUT: begin
                if (bufWRDY) state_d = ST_INC;
            end
            ST_INC: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = ST_WAIT;
            end
            // WAIT gives the RH11 one cycle to reflect the increment on mbWCZ
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    secdone_d = 1'b1;
                    state_d   = (mbWCZ || wce_q) ? ST_DONE : next_word;
                end else if (mbWCZ) begin
                    state_d = (cmd_q == CMD_WRITE) ? ST_PAD : ST_DONE;
                end else begin
                    state_d = next_word;
                end
            end
            ST_PAD: begin
                if (bufWRDY) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        secdone_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (mbINIT) begin
            state_d   = ST_IDLE;
            cmd_d     = CMD_READ;
            cnt_d     = '0;
            data_d    = '0;
            wce_d     = 1'b0;
            secdone_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cmd_q     <= CMD_READ;
            cnt_q     <= '0;
            data_q    <= '0;
            wce_q     <= 1'b0;
            secdone_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            wce_q     <= wce_d;
            secdone_q <= secdone_d;
        end
    end

    assign mbREQO   = (state_q == ST_REQ);
    assign mbINCWC  = (state_q == ST_INC);
    assign mbINCBA  = (state_q == ST_INC);
    assign mbNPRO   = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bufRRDY  = (state_q == ST_FETCH);
    assign bufWVLD  = (state_q == ST_PUT) || (state_q == ST_PAD);
    assign bufWDAT  = (state_q == ST_PAD) ? 36'b0 : data_q;
    assign mbDATAO  = (cmd_q == CMD_READ) ? data_q : 36'b0;
    assign mbWCE    = wce_q;
    assign secDONE  = secdone_q;
    assign xferDONE = (state_q == ST_DONE);

`ifdef RPXX_MBXFER_PAR_EN
    logic pat_q, pat_d;

    always_comb begin
        pat_d = pat_q;
        if (mbINIT)                          pat_d = 1'b0;
        else if (state_q == ST_IDLE && mbGO) pat_d = mbPAT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pat_q <= 1'b0;
        else      pat_q <= pat_d;
    end

    assign mbINVPAR = mbREQO && pat_q && (cmd_q == CMD_READ);
`else
    logic unused_pat;
    assign unused_pat = mbPAT;
    assign mbINVPAR   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rpxx_mbxfer.sv
// ============================================================================
// Module  : tb_rpxx_mbxfer
// Brief   : Directed self-checking bench for rpxx_mbxfer with SECWORDS=4.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rpxx_mbxfer;
    import rpxx_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mbINIT, mbGO, mbPAT, mbWCZ, mbACKI;
    logic [4:0]  mbFUN;
    logic [35:0] mbDATAI;
    logic        mbREQO, mbINCWC, mbINCBA, mbWCE, mbNPRO, mbINVPAR;
    logic [35:0] mbDATAO;
    logic [35:0] bufRDAT, bufWDAT;
    logic        bufRVLD, bufRRDY, bufWVLD, bufWRDY;
    logic        secDONE, xferDONE;

    always #5 clk = ~clk;

    rpxx_mbxfer #(.SECWORDS(4)) dut (
        .clk(clk), .rst(rst), .mbINIT(mbINIT), .mbGO(mbGO), .mbFUN(mbFUN), .mbPAT(mbPAT),
        .mbWCZ(mbWCZ), .mbACKI(mbACKI), .mbDATAI(mbDATAI), .mbREQO(mbREQO), .mbDATAO(mbDATAO),
        .mbINCWC(mbINCWC), .mbINCBA(mbINCBA), .mbWCE(mbWCE), .mbNPRO(mbNPRO), .mbINVPAR(mbINVPAR),
        .bufRDAT(bufRDAT), .bufRVLD(bufRVLD), .bufRRDY(bufRRDY), .bufWDAT(bufWDAT),
        .bufWVLD(bufWVLD), .bufWRDY(bufWRDY), .secDONE(secDONE), .xferDONE(xferDONE)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [35:0] rdword [16];
    logic [35:0] wrsrc  [16];
    logic [35:0] bufw   [16];
    logic [35:0] datao_seen [16];
    int   n_ack, n_inc, n_sec, n_xdone, n_rd, n_bufw;
    int   n_reqo_after_ack, n_invpar_bad, n_invpar_hi, stall_cycles, n_lat_bad, n_incba_bad;
    logic timeout, init_fired, exp_par;

    task automatic clear_stats();
        n_ack = 0; n_inc = 0; n_sec = 0; n_xdone = 0; n_rd = 0; n_bufw = 0;
        n_reqo_after_ack = 0; n_invpar_bad = 0; n_invpar_hi = 0; stall_cycles = 0;
        n_lat_bad = 0; n_incba_bad = 0; timeout = 1'b0; init_fired = 1'b0;
        for (int i = 0; i < 16; i++) begin bufw[i] = '0; datao_seen[i] = '0; end
    endtask

    task automatic start(input logic [4:0] fun, input logic pat);
        mbFUN = fun; mbPAT = pat; mbGO = 1'b1;
        @(posedge clk); #1;
        mbGO = 1'b0;
`ifdef RPXX_MBXFER_PAR_EN
        exp_par = pat && (fun == FUN_READ);
`else
        exp_par = 1'b0;
`endif
    endtask

    // Models the buffer and the RH11: supplies buffer words, acks every request,
    // raises WCZ once wcz_n increments have been seen, optionally fires mbINIT.
    task automatic service(input logic [4:0] fun, input int wcz_n, input int stall, input int init_at);
        int   stall_left = stall;
        logic prev_ack   = 1'b0;
        logic prev_fire  = 1'b0;
        bit   done       = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            if (mbINCWC) begin n_inc++; if (!mbINCBA) n_incba_bad++; end
            if (secDONE) n_sec++;
            if (prev_ack && mbREQO) n_reqo_after_ack++;
            if (prev_fire && !mbREQO && fun != FUN_WRITE) n_lat_bad++;
            if (mbINVPAR !== (exp_par & mbREQO)) n_invpar_bad++;
            if (mbINVPAR) n_invpar_hi++;
            if (mbREQO && n_ack < 16) datao_seen[n_ack] = mbDATAO;
            if (xferDONE) begin n_xdone++; done = 1'b1; end
            mbWCZ   = (n_inc >= wcz_n);
            bufRVLD = 1'b0;
            if (bufRRDY) begin
                if (stall_left > 0) begin stall_left--; stall_cycles++; end
                else begin bufRVLD = 1'b1; bufRDAT = rdword[n_rd]; end
            end
            prev_fire = bufRRDY && bufRVLD;
            if (prev_fire) n_rd++;
            if (bufWVLD && n_bufw < 16) begin bufw[n_bufw] = bufWDAT; n_bufw++; end
            mbACKI = 1'b0;
            if (mbREQO && !prev_ack) begin
                if (init_at >= 0 && n_ack == init_at) begin
                    mbINIT = 1'b1; init_fired = 1'b1; done = 1'b1;
                end else begin
                    mbACKI = 1'b1; mbDATAI = wrsrc[n_ack]; n_ack++;
                end
            end
            prev_ack = mbACKI;
        end
        if (!done) timeout = 1'b1;
        if (!init_fired) begin
            @(posedge clk); #1;
            mbACKI = 1'b0; bufRVLD = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if ({mbREQO, mbNPRO, mbWCE, bufRRDY, bufWVLD, xferDONE, secDONE} !== 7'b0) begin n_fail++; $display("FAIL reset_ctl: got %b expected 0000000", {mbREQO, mbNPRO, mbWCE, bufRRDY, bufWVLD, xferDONE, secDONE}); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (mbDATAO !== 36'b0 || mbINCWC !== 1'b0 || mbINVPAR !== 1'b0) begin n_fail++; $display("FAIL reset_data: got datao=%h incwc=%b invpar=%b expected zeros", mbDATAO, mbINCWC, mbINVPAR); end
        start(5'o01, 1'b0);
        @(posedge clk); #1;
        n_checks++; if ({mbNPRO, bufRRDY, mbREQO} !== 3'b0) begin n_fail++; $display("FAIL bad_fun_ignored: got %b expected 000", {mbNPRO, bufRRDY, mbREQO}); end
    endtask

    task automatic test_read();
        clear_stats();
        start(FUN_READ, 1'b0);
        service(FUN_READ, 3, 0, -1);
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL read_timeout: got %b expected 0", timeout); end
        n_checks++; if (n_ack !== 3) begin n_fail++; $display("FAIL read_acks: got %0d expected 3", n_ack); end
        n_checks++; if (n_inc !== 3 || n_incba_bad !== 0) begin n_fail++; $display("FAIL read_inc: got %0d/%0d expected 3/0", n_inc, n_incba_bad); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (datao_seen[i] !== rdword[i]) begin n_fail++; $display("FAIL read_datao%0d: got %h expected %h", i, datao_seen[i], rdword[i]); end
        end
        n_checks++; if (n_xdone !== 1 || n_sec !== 0) begin n_fail++; $display("FAIL read_done: got xdone=%0d sec=%0d expected 1/0", n_xdone, n_sec); end
        n_checks++; if (n_reqo_after_ack !== 0 || n_lat_bad !== 0) begin n_fail++; $display("FAIL read_timing: got %0d/%0d expected 0/0", n_reqo_after_ack, n_lat_bad); end
    endtask

    task automatic test_write();
        clear_stats();
        start(FUN_WRITE, 1'b0);
        service(FUN_WRITE, 2, 0, -1);
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL write_timeout: got %b expected 0", timeout); end
        n_checks++; if (n_bufw !== 4) begin n_fail++; $display("FAIL write_nbuf: got %0d expected 4", n_bufw); end
        n_checks++; if (bufw[0] !== wrsrc[0] || bufw[1] !== wrsrc[1]) begin n_fail++; $display("FAIL write_data: got %h %h expected %h %h", bufw[0], bufw[1], wrsrc[0], wrsrc[1]); end
        n_checks++; if (bufw[2] !== 36'b0 || bufw[3] !== 36'b0) begin n_fail++; $display("FAIL write_pad: got %h %h expected 0 0", bufw[2], bufw[3]); end
        n_checks++; if (n_ack !== 2 || n_inc !== 2) begin n_fail++; $display("FAIL write_counts: got ack=%0d inc=%0d expected 2/2", n_ack, n_inc); end
        n_checks++; if (n_sec !== 1 || n_xdone !== 1) begin n_fail++; $display("FAIL write_done: got sec=%0d xdone=%0d expected 1/1", n_sec, n_xdone); end
    endtask

    task automatic test_wrchk();
        clear_stats();
        rdword[2] = 36'o0; wrsrc[2] = 36'o1;
        start(FUN_WRCHK, 1'b0);
        service(FUN_WRCHK, 99, 0, -1);
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL wrchk_timeout: got %b expected 0", timeout); end
        n_checks++; if (n_ack !== 4 || n_inc !== 4) begin n_fail++; $display("FAIL wrchk_counts: got ack=%0d inc=%0d expected 4/4", n_ack, n_inc); end
        n_checks++; if (n_sec !== 1 || n_xdone !== 1) begin n_fail++; $display("FAIL wrchk_done: got sec=%0d xdone=%0d expected 1/1", n_sec, n_xdone); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (mbWCE !== 1'b1) begin n_fail++; $display("FAIL wrchk_wce_sticky: got %b expected 1", mbWCE); end
        n_checks++; if (mbDATAO !== 36'b0) begin n_fail++; $display("FAIL wrchk_datao: got %h expected 0", mbDATAO); end
        rdword[2] = 36'h8_1234_5670 + 36'h2_0202_0202;
    endtask

    task automatic test_stall();
        clear_stats();
        start(FUN_READ, 1'b0);
        n_checks++; if (mbWCE !== 1'b0) begin n_fail++; $display("FAIL go_clears_wce: got %b expected 0", mbWCE); end
        service(FUN_READ, 8, 5, -1);
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL stall_timeout: got %b expected 0", timeout); end
        n_checks++; if (stall_cycles !== 5 || n_lat_bad !== 0) begin n_fail++; $display("FAIL stall_hold: got stall=%0d lat=%0d expected 5/0", stall_cycles, n_lat_bad); end
        n_checks++; if (n_ack !== 8 || n_sec !== 2 || n_xdone !== 1) begin n_fail++; $display("FAIL stall_counts: got ack=%0d sec=%0d xdone=%0d expected 8/2/1", n_ack, n_sec, n_xdone); end
        n_checks++; if (datao_seen[5] !== rdword[5]) begin n_fail++; $display("FAIL stall_datao5: got %h expected %h", datao_seen[5], rdword[5]); end
    endtask

    task automatic test_init();
        int xd = 0;
        clear_stats();
        start(FUN_READ, 1'b0);
        service(FUN_READ, 99, 0, 1);
        n_checks++; if (init_fired !== 1'b1) begin n_fail++; $display("FAIL init_reached_req2: got %b expected 1", init_fired); end
        @(posedge clk); #1;
        mbINIT = 1'b0;
        n_checks++; if (mbREQO !== 1'b0 || mbNPRO !== 1'b0) begin n_fail++; $display("FAIL init_abort: got reqo=%b npro=%b expected 0/0", mbREQO, mbNPRO); end
        for (int i = 0; i < 6; i++) begin
            if (xferDONE) xd++;
            @(posedge clk); #1;
        end
        n_checks++; if (xd !== 0) begin n_fail++; $display("FAIL init_no_xferdone: got %0d expected 0", xd); end
        clear_stats();
        start(FUN_READ, 1'b0);
        service(FUN_READ, 2, 0, -1);
        n_checks++; if (n_ack !== 2 || n_xdone !== 1 || n_sec !== 0) begin n_fail++; $display("FAIL init_rerun: got ack=%0d xdone=%0d sec=%0d expected 2/1/0", n_ack, n_xdone, n_sec); end
        n_checks++; if (datao_seen[0] !== rdword[0] || datao_seen[1] !== rdword[1]) begin n_fail++; $display("FAIL init_rerun_data: got %h %h expected %h %h", datao_seen[0], datao_seen[1], rdword[0], rdword[1]); end
    endtask

    task automatic test_parity();
        int exp_hi;
`ifdef RPXX_MBXFER_PAR_EN
        exp_hi = 2;
`else
        exp_hi = 0;
`endif
        clear_stats();
        start(FUN_READ, 1'b1);
        service(FUN_READ, 2, 0, -1);
        n_checks++; if (n_invpar_bad !== 0) begin n_fail++; $display("FAIL invpar_align: got %0d bad cycles expected 0", n_invpar_bad); end
        n_checks++; if (n_invpar_hi !== exp_hi) begin n_fail++; $display("FAIL invpar_count: got %0d expected %0d", n_invpar_hi, exp_hi); end
    endtask

    initial begin
        mbINIT = 1'b0; mbGO = 1'b0; mbFUN = 5'o0; mbPAT = 1'b0; mbWCZ = 1'b0; mbACKI = 1'b0;
        mbDATAI = '0; bufRDAT = '0; bufRVLD = 1'b0; bufWRDY = 1'b1; exp_par = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rdword[i] = 36'h8_1234_5670 + 36'(i) * 36'h1_0101_0101;
            wrsrc[i]  = 36'h5_A5A5_0000 + 36'(i);
        end
        clear_stats();
        test_reset();
        test_read();
        test_write();
        for (int i = 0; i < 16; i++) wrsrc[i] = rdword[i];
        test_wrchk();
        test_stall();
        test_init();
        test_parity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
